// File: rtl/uart_rx_byte_if.sv
// UART receive-side signal bundle: serial pin in, framed byte and strobes out.
// master = receiver, slave = pin driver / byte consumer.
interface uart_rx_byte_if;
  logic       UART_RX;
  logic [7:0] rxd;
  logic       RECEIVE_END;
  logic       FRAME_ERR;
  logic       rx_busy;

  modport master (
    input  UART_RX,
    output rxd,
    output RECEIVE_END,
    output FRAME_ERR,
    output rx_busy
  );

  modport slave (
    output UART_RX,
    input  rxd,
    input  RECEIVE_END,
    input  FRAME_ERR,
    input  rx_busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises RX, centre-samples each bit,
// presents the byte on rxd with a one-cycle RECEIVE_END / FRAME_ERR strobe.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic          iCLK,
  input  logic          RST_n,
  uart_rx_byte_if.master rx
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    rxd_q, rxd_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          dly_q, dly_d;
  logic          start_det;

  // sync_q is the usable line value; dly_q lags it by one cycle
  assign start_det = dly_q & ~sync_q;

  always_comb begin
    meta_d  = rx.UART_RX;
    sync_d  = meta_q;
    dly_d   = sync_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    rxd_d   = rxd_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_det) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sync_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shreg_d = {sync_q, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        // leave mid stop bit so a start edge right after it is caught
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (sync_q) begin
            rxd_d  = shreg_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!RST_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      rxd_q   <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      dly_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      rxd_q   <= rxd_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      dly_q   <= dly_d;
    end
  end

  assign rx.rxd         = rxd_q;
  assign rx.RECEIVE_END = done_q;
  assign rx.FRAME_ERR   = ferr_q;
  assign rx.rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: directed frames plus random bytes, checked
// against an arithmetic sample-point model of the received line.
module tb_uart_rx_byte;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 3;

  typedef struct {
    int         cyc;
    logic       ferr;
    logic [7:0] data;
  } ev_t;

  logic iclk  = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  uart_rx_byte_if bus();

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .iCLK  (iclk),
    .RST_n (rst_n),
    .rx    (bus.master)
  );

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;

  ev_t        exp_q[$];
  ev_t        act_q[$];
  ev_t        mon_e;
  int         vectors     = 0;
  int         miscompares = 0;
  int         both_hi     = 0;
  int         adjacent    = 0;
  logic       prev_strobe = 1'b0;
  logic       strobe;
  logic [7:0] last_good   = 8'h00;

  always @(negedge iclk) begin
    strobe = rst_n && (bus.RECEIVE_END || bus.FRAME_ERR);
    if (strobe) begin
      mon_e.cyc  = cyc;
      mon_e.ferr = bus.FRAME_ERR;
      mon_e.data = bus.rxd;
      act_q.push_back(mon_e);
    end
    if (rst_n && bus.RECEIVE_END && bus.FRAME_ERR) both_hi++;
    if (strobe && prev_strobe) adjacent++;
    prev_strobe = strobe;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input logic v);
    bus.UART_RX = v;
    @(posedge iclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1);
  endtask

  // line level t cycles after the start edge of an ideal TX frame
  function automatic logic line_at(input logic [7:0] b, input int p,
                                   input logic stop_ok, input int t);
    int pos;
    pos = t / p;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pos == 9) return stop_ok;
    return 1'b1;
  endfunction

  task automatic send(input logic [7:0] b, input int p,
                      input logic stop_ok, input int gap);
    ev_t        e;
    logic [7:0] got;
    logic       lvl;
    for (int k = 0; k < 8; k++)
      got[k] = line_at(b, p, stop_ok, HALF + (k + 1) * CPB);
    e.cyc  = cyc + LAT + HALF + 9 * CPB;
    e.ferr = !line_at(b, p, stop_ok, HALF + 9 * CPB);
    if (!e.ferr) last_good = got;
    e.data = last_good;
    exp_q.push_back(e);
    for (int j = 0; j < 10; j++) begin
      if (j == 0) lvl = 1'b0;
      else if (j < 9) lvl = b[j-1];
      else lvl = stop_ok;
      repeat (p) tick(lvl);
    end
    idle(gap);
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      chk({tag, "_cycle"}, act_q[i].cyc, exp_q[i].cyc);
      chk({tag, "_ferr"}, act_q[i].ferr, exp_q[i].ferr);
      chk({tag, "_rxd"}, act_q[i].data, exp_q[i].data);
    end
    exp_q.delete();
    act_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] msg [5];
    logic [7:0] rb;
    logic       ok;
    int         gap;
    msg[0] = 8'h2C; msg[1] = 8'h32; msg[2] = 8'h3A;
    msg[3] = 8'h33; msg[4] = 8'h0D;

    bus.UART_RX = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge iclk);
    #1;
    chk("rst_rxd", bus.rxd, 8'h00);
    chk("rst_recv_end", bus.RECEIVE_END, 1'b0);
    chk("rst_frame_err", bus.FRAME_ERR, 1'b0);
    chk("rst_busy", bus.rx_busy, 1'b0);
    rst_n = 1'b1;
    idle(10);

    send(8'h2C, CPB, 1'b1, 20);
    check_events("single");

    foreach (msg[i]) send(msg[i], CPB, 1'b1, 0);
    idle(20);
    check_events("burst");

    repeat (5) tick(1'b0);
    chk("glitch_busy_hi", bus.rx_busy, 1'b1);
    idle(30);
    chk("glitch_busy_lo", bus.rx_busy, 1'b0);
    chk("glitch_rxd", bus.rxd, last_good);
    check_events("glitch");

    send(8'h55, CPB, 1'b0, 0);
    repeat (30) tick(1'b0);
    idle(20);
    send(8'h0D, CPB, 1'b1, 20);
    check_events("frame_err");

    repeat (CPB) tick(1'b0);
    repeat (4 * CPB) tick(1'b0);
    repeat (HALF) tick(1'b1);
    chk("abort_busy", bus.rx_busy, 1'b1);
    rst_n = 1'b0;
    tick(1'b1);
    chk("abort_rxd", bus.rxd, 8'h00);
    chk("abort_recv_end", bus.RECEIVE_END, 1'b0);
    chk("abort_frame_err", bus.FRAME_ERR, 1'b0);
    chk("abort_busy_lo", bus.rx_busy, 1'b0);
    rst_n = 1'b1;
    last_good = 8'h00;
    idle(40);
    check_events("abort");
    send(8'hA5, CPB, 1'b1, 20);
    check_events("after_abort");

    send(8'hF0, CPB - 1, 1'b1, 30);
    send(8'hF0, CPB + 1, 1'b1, 30);
    send(8'h0F, CPB - 1, 1'b1, 30);
    send(8'h0F, CPB + 1, 1'b1, 30);
    check_events("skew");

    repeat (12) begin
      rb  = 8'($urandom);
      ok  = ($urandom_range(5) != 0);
      gap = ok ? int'($urandom_range(12)) : int'($urandom_range(12, 2));
      send(rb, CPB, ok, gap);
    end
    idle(20);
    check_events("random");

    chk("both_strobes_high", both_hi, 0);
    chk("adjacent_strobes", adjacent, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
